life_pixel_renderer: RTL and testbench



---
 rtl/life_pkg.sv | 26 ++
 rtl/life_popcount_scanner.sv | 68 ++++++
 rtl/life_pixel_renderer.sv | 127 ++++++++++++
 tb/tb_life_pixel_renderer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants, colours and scan-state encoding for the life-grid
// pixel renderer and its population scanner.
package life_pkg;

  localparam int unsigned L        = 16;
  localparam int unsigned L2       = L * L;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned LOG_L    = $clog2(L);
  localparam int unsigned IDX_W    = $clog2(L2);
  localparam int unsigned POP_W    = $clog2(L2) + 1;
  localparam int unsigned ZOOM_W   = 3;
  localparam int unsigned RGB_W    = 4;
  localparam int unsigned ACTIVE_W = 480;
  localparam int unsigned V_SNAP   = 480;

  localparam logic [RGB_W-1:0] ALIVE_RGB = 4'h1;
  localparam logic [RGB_W-1:0] DARK_RGB  = 4'hC;
  localparam logic [RGB_W-1:0] LIGHT_RGB = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/life_popcount_scanner.sv
// Serial live-cell counter: walks the grid snapshot one cell per clock after
// each snapshot strobe and publishes the total with a one-cycle valid pulse.
module life_popcount_scanner
  import life_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             snap_i,
  input  logic [L2-1:0]    status_snap_i,
  output logic [POP_W-1:0] population_o,
  output logic             population_valid_o
);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [POP_W-1:0] acc_q, acc_d;
  logic [POP_W-1:0] pop_q, pop_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      acc_q   <= '0;
      pop_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      acc_q   <= acc_d;
      pop_q   <= pop_d;
      valid_q <= valid_d;
    end
  end

  // A new snapshot always restarts the walk, discarding any partial count.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    acc_d   = acc_q;
    pop_d   = pop_q;
    valid_d = 1'b0;
    if (snap_i) begin
      state_d = SCAN;
      index_d = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SCAN: begin
          acc_d   = acc_q + POP_W'(status_snap_i[index_q]);
          index_d = index_q + IDX_W'(1);
          if (index_q == IDX_W'(L2 - 1)) begin
            state_d = DONE;
            pop_d   = acc_d;
            valid_d = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign population_o       = pop_q;
  assign population_valid_o = valid_q;

endmodule

// File: rtl/life_pixel_renderer.sv
// Renders a once-per-frame snapshot of the life grid onto the 480p raster
// with zoom/pan, two-stage registered RGB and matching sync delay.
module life_pixel_renderer
  import life_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst,
  input  logic [L2-1:0]      status,
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  input  logic               de,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [ZOOM_W-1:0]  zoom,
  input  logic [LOG_L-1:0]   pan_x,
  input  logic [LOG_L-1:0]   pan_y,
  output logic [RGB_W-1:0]   vga_r,
  output logic [RGB_W-1:0]   vga_g,
  output logic [RGB_W-1:0]   vga_b,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [POP_W-1:0]   population,
  output logic               population_valid
);

  logic snap_c;

  logic [L2-1:0]     status_snap_q, status_snap_d;
  logic [ZOOM_W-1:0] zoom_snap_q, zoom_snap_d;
  logic [LOG_L-1:0]  pan_x_snap_q, pan_x_snap_d;
  logic [LOG_L-1:0]  pan_y_snap_q, pan_y_snap_d;

  logic [LOG_L-1:0]  cx_q, cx_d;
  logic [LOG_L-1:0]  cy_q, cy_d;
  logic              checker_q, checker_d;
  logic              visible_q, visible_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;

  logic [IDX_W-1:0]  idx_c;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              hs2_q, hs2_d;
  logic              vs2_q, vs2_d;

  // Snapshot on the first blanking line so the whole visible frame is coherent.
  assign snap_c = (sy == COORD_W'(V_SNAP)) && (sx == '0);

  // L is a power of two, so L-1-c is the bitwise inverse of c.
  assign idx_c = {~cy_q, ~cx_q};

  always_comb begin
    status_snap_d = status_snap_q;
    zoom_snap_d   = zoom_snap_q;
    pan_x_snap_d  = pan_x_snap_q;
    pan_y_snap_d  = pan_y_snap_q;
    if (snap_c) begin
      status_snap_d = status;
      zoom_snap_d   = zoom;
      pan_x_snap_d  = pan_x;
      pan_y_snap_d  = pan_y;
    end

    cx_d      = LOG_L'(sx >> zoom_snap_q) + pan_x_snap_q;
    cy_d      = LOG_L'(sy >> zoom_snap_q) + pan_y_snap_q;
    checker_d = sx[zoom_snap_q] ^ sy[zoom_snap_q];
    visible_d = de && (sx < COORD_W'(ACTIVE_W));
    hs1_d     = hsync_in;
    vs1_d     = vsync_in;

    rgb_d = '0;
    if (visible_q) begin
      if (status_snap_q[idx_c]) rgb_d = ALIVE_RGB;
      else if (checker_q)       rgb_d = DARK_RGB;
      else                      rgb_d = LIGHT_RGB;
    end
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      status_snap_q <= '0;
      zoom_snap_q   <= '0;
      pan_x_snap_q  <= '0;
      pan_y_snap_q  <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      checker_q     <= 1'b0;
      visible_q     <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      rgb_q         <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
    end else begin
      status_snap_q <= status_snap_d;
      zoom_snap_q   <= zoom_snap_d;
      pan_x_snap_q  <= pan_x_snap_d;
      pan_y_snap_q  <= pan_y_snap_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      checker_q     <= checker_d;
      visible_q     <= visible_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      rgb_q         <= rgb_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
    end
  end

  assign vga_r     = rgb_q;
  assign vga_g     = rgb_q;
  assign vga_b     = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

  life_popcount_scanner u_scanner (
    .clk_in             (clk_in),
    .rst                (rst),
    .snap_i             (snap_c),
    .status_snap_i      (status_snap_q),
    .population_o       (population),
    .population_valid_o (population_valid)
  );

endmodule

// File: tb/tb_life_pixel_renderer.sv
// Self-checking bench for life_pixel_renderer: pixel vectors scored two
// cycles after drive, plus population-pulse and reset sequences.
module tb_life_pixel_renderer;
  import life_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst = 1'b1;
  logic [L2-1:0]      status = '0;
  logic [COORD_W-1:0] sx = COORD_W'(700);
  logic [COORD_W-1:0] sy = COORD_W'(481);
  logic               de = 1'b0;
  logic               hsync_in = 1'b1;
  logic               vsync_in = 1'b1;
  logic [ZOOM_W-1:0]  zoom = '0;
  logic [LOG_L-1:0]   pan_x = '0;
  logic [LOG_L-1:0]   pan_y = '0;
  logic [RGB_W-1:0]   vga_r, vga_g, vga_b;
  logic               hsync_out, vsync_out;
  logic [POP_W-1:0]   population;
  logic               population_valid;

  life_pixel_renderer dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .status           (status),
    .sx               (sx),
    .sy               (sy),
    .de               (de),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .zoom             (zoom),
    .pan_x            (pan_x),
    .pan_y            (pan_y),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .hsync_out        (hsync_out),
    .vsync_out        (vsync_out),
    .population       (population),
    .population_valid (population_valid)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         x;
    int         y;
    logic       d;
    logic       h;
    logic       v;
    logic [3:0] rgb;
  } vec_t;

  typedef struct {
    int         tag;
    int         x;
    int         y;
    logic [3:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sbq[$];
  int   pulse_cyc[$];
  int   pulse_pop[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input int x, input int y, input logic d, input logic h,
                              input logic v, input logic [3:0] rgb);
    vec_t r;
    r.x = x; r.y = y; r.d = d; r.h = h; r.v = v; r.rgb = rgb;
    return r;
  endfunction

  function automatic logic [L2-1:0] glider();
    logic [L2-1:0] g;
    g = '0;
    g[1] = 1'b1; g[18] = 1'b1; g[32] = 1'b1; g[33] = 1'b1; g[34] = 1'b1;
    return g;
  endfunction

  // Output monitor: scoreboard entries are due two cycles after their drive cycle.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!rst) begin
      if (population_valid) begin
        pulse_cyc.push_back(cyc);
        pulse_pop.push_back(int'(population));
      end
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
        e = sbq.pop_front();
        if (e.tag < cyc) begin
          chk($sformatf("late px(%0d,%0d)", e.x, e.y), 32'(cyc), 32'(e.tag));
        end else begin
          chk($sformatf("rgb px(%0d,%0d)", e.x, e.y), 32'({vga_r, vga_g, vga_b}),
              32'({e.rgb, e.rgb, e.rgb}));
          chk($sformatf("hsync px(%0d,%0d)", e.x, e.y), 32'(hsync_out), 32'(e.hs));
          chk($sformatf("vsync px(%0d,%0d)", e.x, e.y), 32'(vsync_out), 32'(e.vs));
        end
      end
    end
  end

  task automatic drive(input int x, input int y, input logic d, input logic h, input logic v);
    @(posedge clk_in);
    #1;
    sx = COORD_W'(x);
    sy = COORD_W'(y);
    de = d;
    hsync_in = h;
    vsync_in = v;
  endtask

  task automatic px(input vec_t t);
    exp_t e;
    drive(t.x, t.y, t.d, t.h, t.v);
    e.tag = cyc + 2; e.x = t.x; e.y = t.y; e.rgb = t.rgb; e.hs = t.h; e.vs = t.v;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(700, 481, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic snap(output int t);
    drive(0, 480, 1'b0, 1'b1, 1'b1);
    t = cyc;
    pulse_cyc.delete();
    pulse_pop.delete();
  endtask

  task automatic check_pop(input int t, input int n, input int exp_pop);
    while (cyc < t + 270) idle(1);
    chk("pulse_count", 32'(pulse_cyc.size()), 32'(n));
    if (n == 1 && pulse_cyc.size() == 1) begin
      chk("pulse_cycle", 32'(pulse_cyc[0] - t), 32'(257));
      chk("pulse_population", 32'(pulse_pop[0]), 32'(exp_pop));
      chk("population_hold", 32'(population), 32'(exp_pop));
    end
  endtask

  vec_t tab2[10];
  vec_t tab3[18];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    int t;
    int t1;

    tab2[0] = mk(0,   0,  1'b1, 1'b1, 1'b1, 4'h1);
    tab2[1] = mk(1,   0,  1'b1, 1'b0, 1'b1, 4'hC);
    tab2[2] = mk(1,   1,  1'b1, 1'b1, 1'b0, 4'hF);
    tab2[3] = mk(16,  0,  1'b1, 1'b0, 1'b0, 4'h1);
    tab2[4] = mk(0,   16, 1'b1, 1'b1, 1'b1, 4'h1);
    tab2[5] = mk(479, 0,  1'b1, 1'b1, 1'b1, 4'hC);
    tab2[6] = mk(480, 0,  1'b1, 1'b1, 1'b1, 4'h0);
    tab2[7] = mk(639, 0,  1'b1, 1'b0, 1'b1, 4'h0);
    tab2[8] = mk(0,   0,  1'b0, 1'b1, 1'b1, 4'h0);
    tab2[9] = mk(17,  17, 1'b1, 1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      tab3[i]     = mk(120 + i, 0, 1'b1, 1'b1, 1'b1, 4'h1);
      tab3[8 + i] = mk(i,       0, 1'b1, 1'b1, 1'b1, 4'hF);
    end
    tab3[16] = mk(0,   8, 1'b1, 1'b1, 1'b1, 4'hC);
    tab3[17] = mk(120, 8, 1'b1, 1'b1, 1'b1, 4'hF);

    // Reset state
    repeat (3) @(posedge clk_in);
    #2;
    chk("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
    chk("reset_hsync", 32'(hsync_out), 32'(1));
    chk("reset_vsync", 32'(vsync_out), 32'(1));
    chk("reset_population", 32'(population), 32'(0));
    chk("reset_valid", 32'(population_valid), 32'(0));
    #1;
    rst = 1'b0;
    idle(2);

    // Single top-left cell, zoom 0, no pan
    status = '0;
    status[L2-1] = 1'b1;
    snap(t);
    for (int i = 0; i < 10; i++) px(tab2[i]);
    check_pop(t, 1, 1);

    // Zoom 3 with horizontal pan wraps column 15 onto cell 0
    zoom = 3'd3;
    pan_x = LOG_L'(1);
    snap(t);
    for (int i = 0; i < 18; i++) px(tab3[i]);
    idle(4);

    // Mid-frame changes stay invisible until the next snapshot
    px(mk(120, 100, 1'b1, 1'b1, 1'b1, 4'hC));
    status = '0;
    status[0] = 1'b1;
    zoom = '0;
    pan_x = '0;
    px(mk(120, 101, 1'b1, 1'b1, 1'b1, 4'hC));
    px(mk(15,  15,  1'b1, 1'b1, 1'b1, 4'hF));
    px(mk(120, 0,   1'b1, 1'b1, 1'b1, 4'h1));
    snap(t);
    px(mk(15,  15,  1'b1, 1'b1, 1'b1, 4'h1));
    px(mk(120, 0,   1'b1, 1'b1, 1'b1, 4'hF));
    check_pop(t, 1, 1);

    // Population: glider, all-ones, and a restarted scan
    status = glider();
    snap(t);
    check_pop(t, 1, 5);
    status = '1;
    snap(t);
    check_pop(t, 1, 256);
    snap(t1);
    while (cyc < t1 + 50) idle(1);
    status = glider();
    snap(t);
    check_pop(t, 1, 5);

    // Reset in the middle of a scan
    status = '1;
    snap(t);
    check_pop(t, 1, 256);
    status = glider();
    snap(t);
    while (cyc < t + 100) drive(1, 1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
    chk("midrst_hsync", 32'(hsync_out), 32'(1));
    chk("midrst_vsync", 32'(vsync_out), 32'(1));
    chk("midrst_population", 32'(population), 32'(0));
    chk("midrst_valid", 32'(population_valid), 32'(0));
    idle(2);
    rst = 1'b0;
    check_pop(t, 0, 0);
    chk("after_rst_population", 32'(population), 32'(0));
    px(mk(0, 0, 1'b1, 1'b1, 1'b1, 4'hF));
    px(mk(1, 0, 1'b1, 1'b1, 1'b1, 4'hC));
    idle(4);
    snap(t);
    check_pop(t, 1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
